alu_share_arb: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_share_arb_rr_pick.sv | 36 +++
 rtl/alu_share_arb.sv | 136 +++++++++++++
 tb/tb_alu_share_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU-sharing arbiter.
//   ALU_LOGWIDTH / ALU_W : default datapath width (W = 2**LOGWIDTH)
//   alu_f_t              : 3-bit ALU function code with named values
//   alu_flags_t          : {cout, oflow, zero}
//   arb_state_t          : arbiter sequencer states
package alu_pkg;

    localparam int ALU_LOGWIDTH = 5;
    localparam int ALU_W        = 2 ** ALU_LOGWIDTH;

    typedef logic [2:0] alu_f_t;
    localparam alu_f_t ALU_AND = 3'b000;
    localparam alu_f_t ALU_OR  = 3'b001;
    localparam alu_f_t ALU_ADD = 3'b010;
    localparam alu_f_t ALU_SUB = 3'b110;
    localparam alu_f_t ALU_SLT = 3'b111;

    typedef struct packed {
        logic cout;
        logic oflow;
        logic zero;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_share_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index (must be < NREQ)
//   grant : one-hot grant of the first set req at or above ptr, wrapping
//   idx   : binary index of the granted requester
//   any   : at least one request present
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int             j;
    logic [IDW-1:0] jj;

    // Scan from farthest to nearest so the requester closest to ptr wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = |req;
        j     = 0;
        jj    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j  = (int'(ptr) + k) % NREQ;
            jj = IDW'(j);
            if (req[jj]) idx = jj;
        end
        if (any) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one combinational ALU among NREQ
// requesters. Each accepted operation is run through the ALU for one cycle
// and returned as a registered, tagged result over a valid/ready handshake.
//
// Optional feature macro: ALU_ARB_B2B_EN -- when defined, a new request may
// be accepted in the same cycle the pending response is taken (2-cycle issue
// interval instead of 3).
//
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   req_valid/req_ready   : per-requester operation handshake (ready one-hot)
//   req_a/req_b/req_f     : packed operands / function, requester i at slot i
//   alu_a/alu_b/alu_f     : to shared ALU, driven from op registers
//   alu_y/alu_flags       : from shared ALU, {cout, oflow, zero}
//   resp_valid/resp_id    : result valid and owning requester
//   resp_y/resp_flags     : registered result and flags
//   resp_ready            : per-requester result accept; only owner's bit used
//
// state    | meaning
// ARB_IDLE | arbitrate; grant first valid requester from pointer
// ARB_EXEC | ALU driven from op registers; capture result at edge
// ARB_RESP | hold result until owner's resp_ready
module alu_share_arb
    import alu_pkg::*;
#(
    parameter  int LOGWIDTH = 5,
    parameter  int NREQ     = 4,
    localparam int W        = 2 ** LOGWIDTH,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    input  logic [NREQ*3-1:0]   req_f,
    output logic [W-1:0]        alu_a,
    output logic [W-1:0]        alu_b,
    output logic [2:0]          alu_f,
    input  logic [W-1:0]        alu_y,
    input  logic [2:0]          alu_flags,
    output logic                resp_valid,
    output logic [IDW-1:0]      resp_id,
    output logic [W-1:0]        resp_y,
    output logic [2:0]          resp_flags,
    input  logic [NREQ-1:0]     resp_ready
);

    arb_state_t     state, state_nx;
    logic [IDW-1:0] ptr;
    logic [W-1:0]   op_a, op_b;
    alu_f_t         op_f;
    logic [IDW-1:0] op_id;
    alu_flags_t     flags_q;

    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            accept;
    logic            resp_fire;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign resp_fire = (state == ARB_RESP) && resp_ready[resp_id];

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    req_ready = pick_grant;
                    accept    = 1'b1;
                    state_nx  = ARB_EXEC;
                end
            end
            ARB_EXEC: state_nx = ARB_RESP;
            ARB_RESP: begin
                if (resp_fire) begin
                    state_nx = ARB_IDLE;
`ifdef ALU_ARB_B2B_EN
                    if (pick_any) begin
                        req_ready = pick_grant;
                        accept    = 1'b1;
                        state_nx  = ARB_EXEC;
                    end
`endif
                end
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ARB_IDLE;
            ptr     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_f    <= '0;
            op_id   <= '0;
            resp_id <= '0;
            resp_y  <= '0;
            flags_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_a  <= req_a[pick_idx*W +: W];
                op_b  <= req_b[pick_idx*W +: W];
                op_f  <= alu_f_t'(req_f[pick_idx*3 +: 3]);
                op_id <= pick_idx;
                ptr   <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            end
            if (state == ARB_EXEC) begin
                resp_y  <= alu_y;
                flags_q <= alu_flags_t'(alu_flags);
                resp_id <= op_id;
            end
        end
    end

    assign alu_a      = op_a;
    assign alu_b      = op_b;
    assign alu_f      = op_f;
    assign resp_valid = (state == ARB_RESP);
    assign resp_flags = flags_q;

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
    import alu_pkg::*;

    localparam int W    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [NREQ*3-1:0] req_f;
    logic [W-1:0]      alu_a, alu_b;
    logic [2:0]        alu_f;
    logic [W-1:0]      alu_y;
    logic [2:0]        alu_flags;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_y;
    logic [2:0]        resp_flags;
    logic [NREQ-1:0]   resp_ready;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_arb #(.LOGWIDTH(5), .NREQ(NREQ)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_f(req_f),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_y(alu_y), .alu_flags(alu_flags),
        .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_y(resp_y), .resp_flags(resp_flags),
        .resp_ready(resp_ready)
    );

    // Minimal ALU model: add for ALU_ADD, bitwise AND otherwise.
    logic [W:0] sum;
    always_comb begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        if (alu_f == ALU_ADD) begin
            alu_y     = sum[W-1:0];
            alu_flags = {sum[W],
                         (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]),
                         sum[W-1:0] == '0};
        end else begin
            alu_y     = alu_a & alu_b;
            alu_flags = {2'b00, (alu_a & alu_b) == '0};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_f[i*3 +: 3] = f;
    endtask

    // Waits (bounded) for any req_ready bit; returns its index and cycle.
    task automatic wait_grant(input string tag, output int idx, output int at);
        idx = -1;
        at  = 0;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (req_ready != '0) begin
                for (int k = 0; k < NREQ; k++) if (req_ready[k]) idx = k;
                at = cyc;
                return;
            end
            tick();
        end
        n_vec++;
        n_err++;
        $error("FAIL %s: observed no grant expected grant within 20 cycles", tag);
    endtask

    initial begin
        int g, t0, t1, exp_int;
        int order[5];
        reset      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        req_a      = '0;
        req_b      = '0;
        req_f      = '0;
        tick(); tick();

        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id",    resp_id, 0);
        check("rst_resp_y",     resp_y, 0);
        check("rst_resp_flags", resp_flags, 0);
        check("rst_req_ready",  req_ready, 0);
        check("rst_alu_a",      alu_a, 0);
        reset = 1'b1;
        tick();

        // Single op from requester 1: 5 + 3.
        set_op(1, 32'h0000_0005, 32'h0000_0003, ALU_ADD);
        req_valid = 4'b0010;
        #1;
        check("single_req_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        #1;
        check("single_exec_valid", resp_valid, 0);
        check("single_exec_ready", req_ready, 0);
        check("single_alu_a", alu_a, 32'h5);
        check("single_alu_f", alu_f, 3'b010);
        tick();
        check("single_resp_valid", resp_valid, 1);
        check("single_resp_id",    resp_id, 1);
        check("single_resp_y",     resp_y, 32'h0000_0008);
        check("single_resp_flags", resp_flags, 3'b000);
        resp_ready = 4'b0010;
        tick();
        resp_ready = '0;
        #1;
        check("single_back_idle", resp_valid, 0);

        // Carry/zero from requester 2, with backpressure and non-owner ready.
        set_op(2, 32'hFFFF_FFFF, 32'h0000_0001, ALU_ADD);
        req_valid = 4'b0100;
        #1;
        check("carry_req_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        tick();
        check("carry_resp_y",     resp_y, 32'h0000_0000);
        check("carry_resp_flags", resp_flags, 3'b101);
        check("carry_resp_id",    resp_id, 2);
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            resp_ready = (i >= 3) ? 4'b1011 : 4'b0000;
            #1;
            check("bp_valid", resp_valid, 1);
            check("bp_id",    resp_id, 2);
            check("bp_y",     resp_y, 32'h0);
            check("bp_flags", resp_flags, 3'b101);
            check("bp_no_ready", req_ready, 0);
            tick();
        end
        req_valid  = '0;
        resp_ready = 4'b0100;
        tick();
        resp_ready = '0;
        #1;
        check("bp_released", resp_valid, 0);

        // Fairness from reset: all valid, all result-ready.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1), 32'h10, ALU_ADD);
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        t0 = 0;
        t1 = 0;
        for (int n = 0; n < 5; n++) begin
            wait_grant("fair_wait", g, exp_int);
            order[n] = g;
            if (n == 0) t0 = exp_int;
            if (n == 1) t1 = exp_int;
            tick();
        end
        check("fair_0", order[0], 0);
        check("fair_1", order[1], 1);
        check("fair_2", order[2], 2);
        check("fair_3", order[3], 3);
        check("fair_4", order[4], 0);
`ifdef ALU_ARB_B2B_EN
        check("issue_interval", t1 - t0, 2);
`else
        check("issue_interval", t1 - t0, 3);
`endif

        // After a grant to 2 with 0 and 3 pending, 3 goes first.
        req_valid = '0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req_valid = 4'b0100;
        wait_grant("rr2_wait", g, exp_int);
        check("rr2_grant", g, 2);
        tick();
        req_valid = 4'b1001;
        wait_grant("rr3_wait", g, exp_int);
        check("rr3_first", g, 3);
        tick();
        req_valid = 4'b0001;
        wait_grant("rr0_wait", g, exp_int);
        check("rr0_second", g, 0);
        tick();
        req_valid = '0;
        tick(); tick(); tick();

        // Reset during ARB_EXEC aborts silently and clears the pointer.
        set_op(1, 32'h1234_0000, 32'h0000_5678, ALU_ADD);
        req_valid = 4'b0010;
        wait_grant("mid_wait", g, exp_int);
        check("mid_grant", g, 1);
        tick();
        req_valid = '0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("mid_resp_valid", resp_valid, 0);
        check("mid_resp_y",     resp_y, 0);
        check("mid_resp_id",    resp_id, 0);
        check("mid_alu_a",      alu_a, 0);
        tick();
        check("mid_no_resp",    resp_valid, 0);
        req_valid = 4'b0101;
        wait_grant("post_wait0", g, exp_int);
        check("post_first", g, 0);
        tick();
        req_valid = 4'b0100;
        wait_grant("post_wait2", g, exp_int);
        check("post_second", g, 2);
        tick();
        req_valid = '0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
